// File: rtl/muxn_rr_reg_pkg.sv
// Shared constants and helpers for the registered round-robin multiplexer.
package muxn_rr_reg_pkg;

  localparam int MUX_MODE_FIXED = 0;
  localparam int MUX_MODE_RR    = 1;

  // Modular add for channel indices, a and b both already below m.
  function automatic int wrap_add(input int a, input int b, input int m);
    int s;
    s = a + b;
    return (s >= m) ? s - m : s;
  endfunction

endpackage

// File: rtl/muxn_rr_reg_arb.sv
// Combinational arbiter: first request at or above ptr (wrapping), or lowest index when rr_en=0.
module rr_arbiter
  import muxn_rr_reg_pkg::*;
#(
  parameter  int M  = 4,
  localparam int CW = $clog2(M)
) (
  input  logic [M-1:0]  req,
  input  logic [CW-1:0] ptr,
  input  logic          rr_en,
  output logic [M-1:0]  grant,
  output logic [CW-1:0] grant_idx
);

  always_comb begin : search
    int   start;
    int   k;
    logic found;
    grant     = '0;
    grant_idx = '0;
    found     = 1'b0;
    k         = 0;
    start     = rr_en ? int'(ptr) : 0;
    for (int i = 0; i < M; i++) begin
      k = wrap_add(start, i, M);
      if (!found && req[CW'(k)]) begin
        found     = 1'b1;
        grant_idx = CW'(k);
      end
    end
    if (found) grant[grant_idx] = 1'b1;
  end

endmodule

// File: rtl/muxn_rr_reg.sv
// M-channel, N-bit valid/ready multiplexer landing the granted word in one output register.
module muxn_rr_reg
  import muxn_rr_reg_pkg::*;
#(
  parameter  int N  = 32,
  parameter  int M  = 4,
  parameter  int RR = MUX_MODE_RR,
  localparam int CW = $clog2(M)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [M*N-1:0]  in_data,
  input  logic [M-1:0]    in_valid,
  output logic [M-1:0]    in_ready,
  input  logic            force_en,
  input  logic [CW-1:0]   force_sel,
  output logic [N-1:0]    out_data,
  output logic [CW-1:0]   out_sel,
  output logic            out_valid,
  input  logic            out_ready
);

  localparam logic RR_EN = (RR == MUX_MODE_RR);

  logic [M-1:0]  elig;
  logic [M-1:0]  grant;
  logic [CW-1:0] grant_idx;
  logic [CW-1:0] ptr;
  logic [N-1:0]  sel_data;
  logic          load;
  logic          xfer;

  assign load = !out_valid || out_ready;

  // An out-of-range forced index leaves nothing eligible.
  always_comb begin
    elig = '0;
    if (force_en) begin
      if (int'(force_sel) < M) elig[force_sel] = in_valid[force_sel];
    end else begin
      elig = in_valid;
    end
  end

  rr_arbiter #(.M(M)) u_arb (
    .req       (elig),
    .ptr       (ptr),
    .rr_en     (RR_EN),
    .grant     (grant),
    .grant_idx (grant_idx)
  );

  // Grant only contains eligible (hence valid) channels, so any grant is a transfer.
  assign in_ready = (load && !rst) ? grant : '0;
  assign xfer     = load && (|grant);

  always_comb begin
    sel_data = '0;
    for (int k = 0; k < M; k++)
      sel_data = sel_data | (in_data[k*N +: N] & {N{grant[k]}});
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_data  <= '0;
      out_sel   <= '0;
      out_valid <= 1'b0;
      ptr       <= '0;
    end else if (load) begin
      if (xfer) begin
        out_data  <= sel_data;
        out_sel   <= grant_idx;
        out_valid <= 1'b1;
        if (RR_EN) ptr <= CW'(wrap_add(int'(grant_idx), 1, M));
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
